display_scan_driver: RTL

Time-multiplexed driver for the 3-digit seven-segment display. It produces the 2-bit digit select consumed by the anode decoder and the active-low segment and decimal-point pattern for the selected digit. A refresh prescaler paces the scan. The shown value is double-buffered and swapped only at frame boundaries, so the display never tears.

---
 rtl/display_scan_driver.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/display_scan_driver.sv
// ---------------------------------------------------------------------------
// display_scan_driver
//
// Time-multiplexed driver for a 3-digit seven-segment display. A refresh
// prescaler paces the digit slots, a small scan state machine walks the
// digit select 0 -> 1 -> 2 -> 0, and the shown value is double-buffered so
// that a new value only takes effect on a frame boundary (no tearing).
//
// Parameters
//   REFRESH_DIV : clk cycles per digit slot (>= 2)
//
// Ports
//   clk        : system clock, rising-edge
//   reset      : asynchronous, active-high reset
//   value      : three hex digits, [3:0] = digit 0 (rightmost)
//   dp_in      : decimal-point enables, bit i for digit i, 1 = lit
//   load       : one-cycle strobe capturing value/dp_in into the pending buffer
//   blank_lz   : 1 = leading-zero blanking enabled
//   sel        : digit select, 0..2 = digit, 3 = all anodes off
//   seg        : {g,f,e,d,c,b,a}, active-low
//   dp         : decimal point, active-low
//   frame_done : one-cycle pulse after each frame boundary
// ---------------------------------------------------------------------------
module display_scan_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] value,
    input  logic [2:0]  dp_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [1:0]  sel,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int PW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {
        DIGIT0     = 2'd0,
        DIGIT1     = 2'd1,
        DIGIT2     = 2'd2,
        RESET_DARK = 2'd3
    } scan_t;

    scan_t       state;
    scan_t       scan_next;
    logic [PW-1:0] pcnt;
    logic        tick;
    logic        boundary;

    logic [11:0] disp_val;
    logic [2:0]  disp_dp;
    logic [11:0] pending_val;
    logic [2:0]  pending_dp;
    logic        pend;

    logic [11:0] next_val;
    logic [2:0]  next_dp;
    logic [3:0]  nibble;
    logic        dp_lit;
    logic        blank;
    logic [6:0]  next_seg;

    // Active-low hex glyphs, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign tick     = (pcnt == PW'(REFRESH_DIV - 1));
    assign boundary = tick && ((state == DIGIT2) || (state == RESET_DARK));
    assign sel      = state;

    // Work out the slot the scan moves into and the display contents that
    // will be in force after this edge, so seg/dp can be registered together
    // with sel and always describe the digit being selected. A load landing
    // on a boundary edge bypasses the pending buffer.
    always_comb begin
        scan_next = DIGIT0;
        unique case (state)
            DIGIT0:  scan_next = DIGIT1;
            DIGIT1:  scan_next = DIGIT2;
            default: scan_next = DIGIT0;
        endcase

        next_val = disp_val;
        next_dp  = disp_dp;
        if (boundary) begin
            if (load) begin
                next_val = value;
                next_dp  = dp_in;
            end else if (pend) begin
                next_val = pending_val;
                next_dp  = pending_dp;
            end
        end

        nibble = next_val[3:0];
        dp_lit = next_dp[0];
        blank  = 1'b0;
        unique case (scan_next)
            DIGIT1: begin
                nibble = next_val[7:4];
                dp_lit = next_dp[1];
                blank  = blank_lz && (next_val[11:4] == 8'h00);
            end
            DIGIT2: begin
                nibble = next_val[11:8];
                dp_lit = next_dp[2];
                blank  = blank_lz && (next_val[11:8] == 4'h0);
            end
            default: begin
                nibble = next_val[3:0];
                dp_lit = next_dp[0];
                blank  = 1'b0;
            end
        endcase

        next_seg = blank ? 7'h7F : hex7(nibble);
    end

    // Prescaler, scan state, double buffer and registered display outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt        <= '0;
            state       <= RESET_DARK;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_done  <= 1'b0;
            disp_val    <= '0;
            disp_dp     <= '0;
            pending_val <= '0;
            pending_dp  <= '0;
            pend        <= 1'b0;
        end else begin
            pcnt       <= tick ? '0 : pcnt + PW'(1);
            frame_done <= boundary;

            if (load) begin
                pending_val <= value;
                pending_dp  <= dp_in;
            end

            if (boundary) begin
                disp_val <= next_val;
                disp_dp  <= next_dp;
                pend     <= 1'b0;
            end else if (load) begin
                pend <= 1'b1;
            end

            if (tick) begin
                state <= scan_next;
                seg   <= next_seg;
                dp    <= ~dp_lit;
            end
        end
    end

endmodule
